// File: rtl/philo_ring_n.sv
// N-philosopher ring: a READING token circulates, hungry philosophers compete for
// their neighbours, optional aging priority, wait counters and a mutual-exclusion monitor.
module philo_ring_n #(
    parameter int N           = 8,
    parameter int INIT_READER = 0,
    parameter int WAIT_W      = 8,
    parameter int MAX_WAIT    = 16,
    parameter int AGING_EN    = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             step,
    input  logic [N-1:0]     coin,
    output logic [2*N-1:0]   state_out,
    output logic [N-1:0]     eating,
    output logic [N-1:0]     starve,
    output logic             mutex_err
);

    typedef enum logic [1:0] {
        THINKING = 2'd0,
        READING  = 2'd1,
        EATING   = 2'd2,
        HUNGRY   = 2'd3
    } phil_t;

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    phil_t             r_state [N];
    logic [WAIT_W-1:0] r_wait  [N];
    logic [N-1:0]      r_starve;
    logic              r_mutex_err;

    phil_t             w_left_st   [N];
    phil_t             w_right_st  [N];
    phil_t             w_state_nxt [N];
    logic [WAIT_W-1:0] w_wait_nxt  [N];
    logic [N-1:0]      w_urgent;
    logic [N-1:0]      w_left_urg;
    logic [N-1:0]      w_right_urg;
    logic [N-1:0]      w_grant;
    logic [N-1:0]      w_starve_nxt;
    logic              w_adj_eat;

    // Aging lets an urgent philosopher overtake its hungry right neighbour and
    // blocks a non-urgent one whose left neighbour is urgent, so two adjacent
    // philosophers can never both be granted on the same edge.
    function automatic logic grant_fn(input phil_t l_st, input phil_t r_st,
                                      input logic u_self, input logic u_l,
                                      input logic u_r);
        logic base;
        base = (l_st != EATING) && (r_st != EATING);
        if (AGING_EN != 0)
            return base && !(u_l && !u_self) && ((r_st != HUNGRY) || (u_self && !u_r));
        else
            return base && (r_st != HUNGRY);
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_ring
        assign w_urgent[gi]    = (r_state[gi] == HUNGRY) && (r_wait[gi] == MAX_W);
        assign w_left_st[gi]   = r_state[(gi + 1) % N];
        assign w_right_st[gi]  = r_state[(gi + N - 1) % N];
        assign w_left_urg[gi]  = w_urgent[(gi + 1) % N];
        assign w_right_urg[gi] = w_urgent[(gi + N - 1) % N];
        assign w_grant[gi]     = (r_state[gi] == HUNGRY) &&
                                 grant_fn(w_left_st[gi], w_right_st[gi], w_urgent[gi],
                                          w_left_urg[gi], w_right_urg[gi]);
        assign state_out[2*gi +: 2] = r_state[gi];
        assign eating[gi]           = (r_state[gi] == EATING);
    end

    always_comb begin
        w_starve_nxt = r_starve;
        for (int i = 0; i < N; i++) begin
            w_state_nxt[i] = r_state[i];
            w_wait_nxt[i]  = r_wait[i];
            case (r_state[i])
                READING: begin
                    if (w_left_st[i] == THINKING)
                        w_state_nxt[i] = THINKING;
                end
                THINKING: begin
                    if (w_right_st[i] == READING)
                        w_state_nxt[i] = READING;
                    else if (!coin[i])
                        w_state_nxt[i] = HUNGRY;
                end
                EATING: begin
                    if (coin[i])
                        w_state_nxt[i] = THINKING;
                end
                HUNGRY: begin
                    if (w_grant[i]) begin
                        w_state_nxt[i] = EATING;
                        w_wait_nxt[i]  = '0;
                    end else if (r_wait[i] != MAX_W) begin
                        w_wait_nxt[i] = r_wait[i] + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = r_state[i];
                end
            endcase
            if (w_wait_nxt[i] == MAX_W)
                w_starve_nxt[i] = 1'b1;
        end
    end

    // bit i pairs philosopher i with its left neighbour (i+1) mod N
    assign w_adj_eat = |(eating & {eating[0], eating[N-1:1]});

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= (i == INIT_READER) ? READING : THINKING;
                r_wait[i]  <= '0;
            end
            r_starve    <= '0;
            r_mutex_err <= 1'b0;
        end else begin
            if (step) begin
                for (int i = 0; i < N; i++) begin
                    r_state[i] <= w_state_nxt[i];
                    r_wait[i]  <= w_wait_nxt[i];
                end
                r_starve <= w_starve_nxt;
            end
            r_mutex_err <= r_mutex_err | w_adj_eat;
        end
    end

    assign starve    = r_starve;
    assign mutex_err = r_mutex_err;

endmodule
